dcache_store_buffer: RTL and testbench

In-order store buffer directly upstream of the dcache controller's write interface. It accepts retired stores from the writeback stage and holds up to DEPTH entries. It issues stores one at a time to the dcache over the wr_valid / wr_ready / wr_done handshake, and flags loads that overlap any pending store so the dcache read path can stall.

---
 rtl/dcache_store_buffer.sv | 171 +++++++++++++++++
 tb/tb_dcache_store_buffer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_store_buffer.sv
// ============================================================================
// dcache_store_buffer : in-order store buffer feeding the dcache write port
// Rev 1.0
// ============================================================================
`default_nettype none

module dcache_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [1:0]               in_size,
  output logic                     wr_valid,
  input  logic                     wr_ready,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic [1:0]               wr_size,
  input  logic                     wr_done,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic [1:0]               ld_size,
  output logic                     ld_conflict,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_WAIT    = 2'd2
  } state_e;

  state_e              state_q;
  logic [PTR_W-1:0]    head_q, tail_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                wr_valid_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic [1:0]          wr_size_q;

  logic [ADDR_W-1:0]   mem_addr_q [DEPTH];
  logic [DATA_W-1:0]   mem_data_q [DEPTH];
  logic [1:0]          mem_size_q [DEPTH];

  logic                push, pop;
  logic [PTR_W-1:0]    head_nxt;
  logic [ADDR_W-1:0]   nxt_addr;
  logic [DATA_W-1:0]   nxt_data;
  logic [1:0]          nxt_size;

  function automatic logic [ADDR_W-1:0] last_byte(input logic [ADDR_W-1:0] a,
                                                  input logic [1:0] sz);
    return a + ((ADDR_W'(1) << sz) - ADDR_W'(1));
  endfunction

  assign in_ready = (count_q != CNT_W'(DEPTH));
  assign push     = in_valid & in_ready;
  assign pop      = (state_q == S_WAIT) & wr_done;
  assign count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  assign head_nxt = head_q + PTR_W'(1);

  // With a single entry left, the next head is the store arriving this cycle,
  // which is not yet in the array.
  always_comb begin
    nxt_addr = mem_addr_q[head_nxt];
    nxt_data = mem_data_q[head_nxt];
    nxt_size = mem_size_q[head_nxt];
    if (count_q == CNT_W'(1)) begin
      nxt_addr = in_addr;
      nxt_data = in_data;
      nxt_size = in_size;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[tail_q] <= in_addr;
      mem_data_q[tail_q] <= in_data;
      mem_size_q[tail_q] <= in_size;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_size_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push) tail_q <= tail_q + PTR_W'(1);
      if (pop)  head_q <= head_nxt;
      case (state_q)
        S_IDLE: begin
          if (push) begin
            state_q    <= S_PRESENT;
            wr_valid_q <= 1'b1;
            wr_addr_q  <= in_addr;
            wr_data_q  <= in_data;
            wr_size_q  <= in_size;
          end
        end
        S_PRESENT: begin
          if (wr_ready) begin
            state_q    <= S_WAIT;
            wr_valid_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (pop) begin
            if (count_d != '0) begin
              state_q    <= S_PRESENT;
              wr_valid_q <= 1'b1;
              wr_addr_q  <= nxt_addr;
              wr_data_q  <= nxt_data;
              wr_size_q  <= nxt_size;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          state_q    <= S_IDLE;
          wr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  logic [ADDR_W-1:0] ld_last;
  logic [DEPTH-1:0]  hit;
  assign ld_last = last_byte(ld_addr, ld_size);

  // An entry is live when its distance from head is below count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [PTR_W-1:0]  rel;
    logic [ADDR_W-1:0] st_last;
    logic              live;
    assign rel     = PTR_W'(i) - head_q;
    assign live    = ({1'b0, rel} < count_q);
    assign st_last = last_byte(mem_addr_q[i], mem_size_q[i]);
    assign hit[i]  = live &
                     ((mem_addr_q[i][ADDR_W-1:3] == ld_addr[ADDR_W-1:3]) |
                      (mem_addr_q[i][ADDR_W-1:3] == ld_last[ADDR_W-1:3]) |
                      (st_last[ADDR_W-1:3]       == ld_addr[ADDR_W-1:3]) |
                      (st_last[ADDR_W-1:3]       == ld_last[ADDR_W-1:3]));
  end

  assign ld_conflict = |hit;
  assign wr_valid    = wr_valid_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign wr_size     = wr_size_q;
  assign count       = count_q;
  assign empty       = (count_q == '0);

endmodule

`default_nettype wire

// File: tb/tb_dcache_store_buffer.sv
// ============================================================================
// tb_dcache_store_buffer : directed + random bench against a queue-based model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dcache_store_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_addr = '0;
  logic [63:0] in_data = '0;
  logic [1:0]  in_size = '0;
  logic        wr_valid;
  logic        wr_ready = 1'b0;
  logic [31:0] wr_addr;
  logic [63:0] wr_data;
  logic [1:0]  wr_size;
  logic        wr_done = 1'b0;
  logic [31:0] ld_addr = 32'h0F00_0000;
  logic [1:0]  ld_size = '0;
  logic        ld_conflict;
  logic [2:0]  count;
  logic        empty;

  dcache_store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(64)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_data(in_data), .in_size(in_size),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_size(wr_size), .wr_done(wr_done),
    .ld_addr(ld_addr), .ld_size(ld_size), .ld_conflict(ld_conflict),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [63:0] d;
    logic [1:0]  s;
  } ent_t;

  ent_t q[$];
  bit   sent;
  ent_t exp_wr;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit overlap(input logic [31:0] a1, input logic [1:0] s1,
                                 input logic [31:0] a2, input logic [1:0] s2);
    logic [31:0] l1, l2, f1b, l1b, f2b, l2b;
    l1 = a1 + (32'd1 << s1) - 32'd1;
    l2 = a2 + (32'd1 << s2) - 32'd1;
    f1b = a1 >> 3; l1b = l1 >> 3;
    f2b = a2 >> 3; l2b = l2 >> 3;
    return (f1b == f2b) || (f1b == l2b) || (l1b == f2b) || (l1b == l2b);
  endfunction

  task automatic compare_model();
    bit conf;
    conf = 1'b0;
    foreach (q[k]) if (overlap(q[k].a, q[k].s, ld_addr, ld_size)) conf = 1'b1;
    chk("in_ready", 64'(in_ready), 64'(q.size() != 4));
    chk("wr_valid", 64'(wr_valid), 64'(q.size() > 0 && !sent));
    chk("wr_addr", 64'(wr_addr), 64'(exp_wr.a));
    chk("wr_data", wr_data, exp_wr.d);
    chk("wr_size", 64'(wr_size), 64'(exp_wr.s));
    chk("count", 64'(count), 64'(q.size()));
    chk("empty", 64'(empty), 64'(q.size() == 0));
    chk("ld_conflict", 64'(ld_conflict), 64'(conf));
  endtask

  task automatic drive(input bit iv, input logic [31:0] a, input logic [63:0] d,
                       input logic [1:0] s, input bit rdy, input bit done);
    @(negedge clk);
    in_valid = iv; in_addr = a; in_data = d; in_size = s;
    wr_ready = rdy; wr_done = done;
    #1;
    compare_model();
  endtask

  task automatic tick();
    bit push, pop, acc;
    @(posedge clk);
    push = in_valid && (q.size() != 4);
    pop  = sent && wr_done;
    acc  = !sent && (q.size() > 0) && wr_ready;
    if (pop) begin
      void'(q.pop_front());
      sent = 1'b0;
    end
    if (acc) sent = 1'b1;
    if (push) q.push_back('{a: in_addr, d: in_data, s: in_size});
    if (q.size() > 0) exp_wr = q[0];
  endtask

  task automatic idle(input bit rdy, input bit done);
    drive(1'b0, 32'h0, 64'h0, 2'd0, rdy, done);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_wr_valid", 64'(wr_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_empty", 64'(empty), 64'd1);
    q.delete();
    sent = 1'b0;
    exp_wr = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rnd_addr();
    if ($urandom_range(0, 3) != 0) return 32'h3000 + 32'($urandom_range(0, 47));
    return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    sent = 1'b0;
    exp_wr = '0;
    #2;
    do_reset();
    chk("rst_wr_addr", 64'(wr_addr), 64'h0);

    // single store
    ld_addr = 32'h1000; ld_size = 2'd0;
    drive(1'b1, 32'h1000, 64'hAB, 2'd0, 1'b0, 1'b0);
    chk("single_conf_empty", 64'(ld_conflict), 64'd0);
    tick();
    idle(1'b1, 1'b0);
    chk("single_wr_valid", 64'(wr_valid), 64'd1);
    chk("single_wr_addr", 64'(wr_addr), 64'h1000);
    chk("single_wr_data", wr_data, 64'hAB);
    chk("single_conf", 64'(ld_conflict), 64'd1);
    tick();
    idle(1'b0, 1'b0);
    chk("single_wait", 64'(wr_valid), 64'd0);
    tick();
    idle(1'b0, 1'b0); tick();
    idle(1'b0, 1'b0); tick();
    idle(1'b0, 1'b1); tick();
    idle(1'b0, 1'b0);
    chk("single_count", 64'(count), 64'd0);
    chk("single_empty", 64'(empty), 64'd1);
    tick();

    // fill to capacity, then drain in order
    ld_addr = 32'h0F00_0000;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h1000 + 32'(8 * k), 64'(k + 1), 2'd3, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h1020, 64'h55, 2'd3, 1'b0, 1'b0);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    chk("fill_count", 64'(count), 64'd4);
    tick();
    idle(1'b1, 1'b0);
    chk("fill_count_held", 64'(count), 64'd4);
    tick();
    idle(1'b0, 1'b1); tick();
    idle(1'b0, 1'b0);
    chk("fill_ready_again", 64'(in_ready), 64'd1);
    tick();
    for (int k = 1; k < 4; k++) begin
      idle(1'b1, 1'b0);
      chk("drain_order", 64'(wr_addr), 64'h1000 + 64'(8 * k));
      tick();
      idle(1'b0, 1'b1); tick();
    end

    // simultaneous enqueue and pop
    drive(1'b1, 32'h4000, 64'hA0, 2'd1, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h4008, 64'hB0, 2'd1, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h4010, 64'hC0, 2'd1, 1'b0, 1'b1);
    chk("simul_count_pre", 64'(count), 64'd2);
    tick();
    idle(1'b0, 1'b0);
    chk("simul_count", 64'(count), 64'd2);
    chk("simul_present", 64'(wr_valid), 64'd1);
    chk("simul_addr", 64'(wr_addr), 64'h4008);
    tick();
    repeat (2) begin
      idle(1'b1, 1'b0); tick();
      idle(1'b0, 1'b1); tick();
    end

    // overlap detection
    drive(1'b1, 32'h2006, 64'h77, 2'd2, 1'b0, 1'b0); tick();
    ld_addr = 32'h2008; ld_size = 2'd0;
    idle(1'b0, 1'b0);
    chk("conf_2008", 64'(ld_conflict), 64'd1);
    tick();
    ld_addr = 32'h2010; ld_size = 2'd3;
    idle(1'b0, 1'b0);
    chk("conf_2010", 64'(ld_conflict), 64'd0);
    tick();
    idle(1'b1, 1'b0); tick();
    idle(1'b0, 1'b1); tick();
    ld_addr = 32'h2008; ld_size = 2'd0;
    idle(1'b0, 1'b0);
    chk("conf_after_pop", 64'(ld_conflict), 64'd0);
    tick();

    // last byte wraps past the top of the address space
    drive(1'b1, 32'hFFFF_FFFE, 64'h99, 2'd2, 1'b0, 1'b0); tick();
    ld_addr = 32'h0; ld_size = 2'd0;
    idle(1'b0, 1'b0);
    chk("conf_wrap", 64'(ld_conflict), 64'd1);
    tick();
    idle(1'b1, 1'b0); tick();
    idle(1'b0, 1'b1); tick();

    // reset while a store is outstanding
    ld_addr = 32'h5000;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h5000 + 32'(8 * k), 64'(k), 2'd0, 1'b0, 1'b0);
      tick();
    end
    idle(1'b1, 1'b0); tick();
    idle(1'b0, 1'b0);
    do_reset();
    idle(1'b0, 1'b1); tick();
    idle(1'b0, 1'b0);
    chk("stray_done_count", 64'(count), 64'd0);
    chk("stray_done_valid", 64'(wr_valid), 64'd0);
    tick();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      ld_addr = rnd_addr();
      ld_size = 2'($urandom_range(0, 3));
      drive(1'($urandom_range(0, 1)), rnd_addr(), {$urandom, $urandom},
            2'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 4) < 2));
      if (n % 1000 == 999) do_reset();
      else tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
